// File: rtl/nat_ingress_pkt_fifo.sv
// Store-and-forward packet FIFO between the 10G MAC RX stream and the NAT
// rewrite stage. Absorbs downstream stalls and releases only complete,
// error-free packets. Packets that overflow the buffer, exceed its depth, or
// end with tuser=1 are dropped whole.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_*              MAC RX stream (no tready; every beat is consumed)
//   m_axis_*              stream towards the NAT stage, registered outputs
//   pkt_cnt / drop_cnt    committed / dropped packet counters (wrapping)
//   level                 committed beats not yet read
module nat_ingress_pkt_fifo #(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           s_axis_tdata,
    input  logic [7:0]            s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_cnt,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned EW    = 73;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_e;

    logic [EW-1:0] mem [DEPTH];

    wr_state_e      state, state_nxt;
    logic [PW-1:0]  wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0]  wr_ptr_nxt, commit_nxt, rd_nxt;
    logic           wr_en_c, pkt_inc_c, drop_inc_c, load_c, full_c;

    // Full uses the pre-edge read pointer: a same-cycle read frees nothing.
    assign full_c = (wr_ptr - rd_ptr) == PW'(DEPTH);

    // Write-side state register and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SYNC;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_nxt;
            if (pkt_inc_c)  pkt_cnt  <= pkt_cnt + 32'd1;
            if (drop_inc_c) drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // Write-side next state: accept, commit on good tlast, roll back on drop
    always_comb begin
        state_nxt  = state;
        wr_en_c    = 1'b0;
        wr_ptr_nxt = wr_ptr;
        commit_nxt = commit_ptr;
        pkt_inc_c  = 1'b0;
        drop_inc_c = 1'b0;
        case (state)
            // Reset may release mid-packet; a valid beat here is a fragment.
            ST_SYNC: state_nxt = s_axis_tvalid ? ST_DROP : ST_WRITE;
            ST_WRITE: begin
                if (s_axis_tvalid) begin
                    if (full_c) begin
                        wr_ptr_nxt = commit_ptr;
                        drop_inc_c = 1'b1;
                        if (!s_axis_tlast) state_nxt = ST_DROP;
                    end else if (s_axis_tlast && s_axis_tuser) begin
                        wr_ptr_nxt = commit_ptr;
                        drop_inc_c = 1'b1;
                    end else begin
                        wr_en_c    = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        if (s_axis_tlast) begin
                            commit_nxt = wr_ptr + PW'(1);
                            pkt_inc_c  = 1'b1;
                        end
                    end
                end
            end
            ST_DROP: if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_WRITE;
            default: state_nxt = ST_SYNC;
        endcase
    end

    // Buffer storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    // Read side sees only committed beats; load when output register is free
    always_comb begin
        load_c = (commit_ptr != rd_ptr) && (!m_axis_tvalid || m_axis_tready);
        rd_nxt = load_c ? rd_ptr + PW'(1) : rd_ptr;
    end

    // Output register and level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            level         <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            level  <= commit_nxt - rd_nxt;
            if (load_c) begin
                {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // Errored packets never leave the block
    assign m_axis_tuser = 1'b0;

endmodule
